// File: rtl/i281_run_controller_if.sv
// ----------------------------------------------------------------------------
// i281_run_controller_if
//
// Purpose:
//   This interface bundles the control and status signals that pass between
//   the board or bench and the i281 run controller. Clock and reset are not
//   part of the bundle; they stay as plain ports on the controller.
//
// Modports:
//   master : the board/bench side. It drives the requests and the CPU status
//            (run, mode, step, step_count, halt_req, pc, bp_addr, bp_enable)
//            and observes the controller outputs.
//   slave  : the controller side. It observes the requests and drives
//            cpu_en, state, cycle_count, halted, done and bp_stop.
//
// Signals:
//   run         level request to start or continue execution
//   mode        00 free-run, 01 single-step, 10 run-N, 11 reserved (hold)
//   step        single-step request; the controller detects its rising edge
//   step_count  cycle count N used in run-N mode
//   halt_req    the CPU reports halt or end of program
//   pc          current CPU program counter
//   bp_addr     breakpoint address
//   bp_enable   breakpoint armed
//   cpu_en      clock enable for every state-holding element of the core
//   state       00 IDLE, 01 RUN, 10 STEP, 11 HALT
//   cycle_count number of cycles with cpu_en=1; saturates instead of wrapping
//   halted      high while in HALT
//   done        one-cycle pulse on the return to IDLE from RUN or STEP
//   bp_stop     high in IDLE after a breakpoint stop
// ----------------------------------------------------------------------------
interface i281_run_controller_if #(
    parameter int PC_WIDTH    = 6,
    parameter int CYCLE_WIDTH = 16,
    parameter int STEP_WIDTH  = 8
);
    logic                   run;
    logic [1:0]             mode;
    logic                   step;
    logic [STEP_WIDTH-1:0]  step_count;
    logic                   halt_req;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    bp_addr;
    logic                   bp_enable;

    logic                   cpu_en;
    logic [1:0]             state;
    logic [CYCLE_WIDTH-1:0] cycle_count;
    logic                   halted;
    logic                   done;
    logic                   bp_stop;

    modport master (
        output run, mode, step, step_count, halt_req, pc, bp_addr, bp_enable,
        input  cpu_en, state, cycle_count, halted, done, bp_stop
    );

    modport slave (
        input  run, mode, step, step_count, halt_req, pc, bp_addr, bp_enable,
        output cpu_en, state, cycle_count, halted, done, bp_stop
    );
endinterface

// File: rtl/i281_run_controller.sv
// ----------------------------------------------------------------------------
// i281_run_controller
//
// Purpose:
//   This is the execution controller for the i281 multicycle CPU. It replaces
//   the single level-sensitive run line with three selectable modes:
//   free-run, single-step and run-N-cycles. It also provides a saturating
//   executed-cycle counter, halt detection and an optional PC breakpoint.
//   The cpu_en output gates every state-holding element of the core.
//
// Ports:
//   clock : system clock; the design acts on the rising edge
//   reset : synchronous, active-high reset; it has priority in every state
//   bus   : i281_run_controller_if.slave. The signals in this bundle are
//           described in the header of the interface file.
//
// Configuration:
//   I281_RUN_BREAKPOINT_EN: when this macro is defined, a PC breakpoint stops
//   RUN before the instruction at bp_addr executes. When it is undefined,
//   bp_hit is constant 0, bp_stop stays 0, and bp_addr, bp_enable and pc are
//   ignored. The ports stay present in both builds.
// ----------------------------------------------------------------------------
module i281_run_controller #(
    parameter int PC_WIDTH    = 6,
    parameter int CYCLE_WIDTH = 16,
    parameter int STEP_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    i281_run_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_e;

    localparam logic [1:0] MODE_FREE  = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_RUN_N = 2'b10;

    localparam logic [STEP_WIDTH-1:0]  REM_ONE   = STEP_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0]  REM_ZERO  = '0;
    localparam logic [CYCLE_WIDTH-1:0] CYCLE_MAX = '1;

    state_e                 state_q,       state_d;
    logic [1:0]             mode_q,        mode_d;
    logic [STEP_WIDTH-1:0]  remaining_q,   remaining_d;
    logic                   bp_skip_q,     bp_skip_d;
    logic                   bp_stop_q,     bp_stop_d;
    logic                   done_q,        done_d;
    logic [CYCLE_WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic                   step_q;

    logic                   step_rise;
    logic                   bp_hit;
    logic                   cpu_en;
    logic [PC_WIDTH-1:0]    pc_w;
    logic [PC_WIDTH-1:0]    bp_addr_w;

    assign pc_w      = bus.pc;
    assign bp_addr_w = bus.bp_addr;

    // A step request counts only on its rising edge. Holding step high
    // therefore produces exactly one single-step.
    assign step_rise = bus.step & ~step_q;

`ifdef I281_RUN_BREAKPOINT_EN
    // bp_skip masks the check for the first RUN cycle after entry. A resume
    // from a breakpoint stop can then execute the instruction at bp_addr and
    // move off it.
    assign bp_hit = bus.bp_enable && (pc_w == bp_addr_w) &&
                    (state_q == ST_RUN) && !bp_skip_q;
`else
    assign bp_hit = 1'b0;

    logic unused_bp;
    assign unused_bp = ^{pc_w, bp_addr_w, bus.bp_enable, bp_skip_q};
`endif

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first. If a branch
        // left a signal unassigned, a latch would be inferred.
        state_d     = state_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        bp_skip_d   = bp_skip_q;
        bp_stop_d   = bp_stop_q;
        done_d      = 1'b0;
        cpu_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The live mode input is consulted only here. The latched copy
                // in mode_q governs the RUN exit conditions.
                case (bus.mode)
                    MODE_FREE: begin
                        if (bus.run) begin
                            state_d   = ST_RUN;
                            mode_d    = MODE_FREE;
                            bp_skip_d = 1'b1;
                            bp_stop_d = 1'b0;
                        end
                    end
                    MODE_STEP: begin
                        if (step_rise) begin
                            state_d = ST_STEP;
                            mode_d  = MODE_STEP;
                        end
                    end
                    MODE_RUN_N: begin
                        if (bus.run) begin
                            if (bus.step_count != REM_ZERO) begin
                                state_d     = ST_RUN;
                                mode_d      = MODE_RUN_N;
                                remaining_d = bus.step_count;
                                bp_skip_d   = 1'b1;
                                bp_stop_d   = 1'b0;
                            end else begin
                                // A zero-length run completes at once. It
                                // still reports done so the requester sees
                                // the completion.
                                done_d = 1'b1;
                            end
                        end
                    end
                    default: ;  // The reserved mode holds in IDLE.
                endcase
            end

            ST_RUN: begin
                cpu_en    = ~bp_hit;
                bp_skip_d = 1'b0;

                if (mode_q == MODE_RUN_N && cpu_en)
                    remaining_d = remaining_q - REM_ONE;

                // The order of these tests sets the exit priority. halt_req
                // comes first, so it wins over a run-N expiry in the same
                // cycle, and the entry to HALT gives no done.
                if (bus.halt_req) begin
                    state_d = ST_HALT;
                end else if (bp_hit) begin
                    state_d   = ST_IDLE;
                    bp_stop_d = 1'b1;
                    done_d    = 1'b1;
                end else if (mode_q == MODE_RUN_N && remaining_q == REM_ONE) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (mode_q == MODE_FREE && !bus.run) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            ST_STEP: begin
                cpu_en = 1'b1;
                if (bus.halt_req) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: ;  // HALT: only reset leaves this state.
        endcase

        // The counter holds at all-ones instead of wrapping to zero.
        if (cpu_en && cycle_count_q != CYCLE_MAX)
            cycle_count_d = cycle_count_q + CYCLE_WIDTH'(1);
        else
            cycle_count_d = cycle_count_q;
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together at the edge, whatever order the statements are in.
    always_ff @(posedge clock) begin
        // NOTE: reset is synchronous. It is sampled at the clock edge like any
        // other input, so it does not appear in the sensitivity list.
        if (reset) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_FREE;
            remaining_q   <= '0;
            bp_skip_q     <= 1'b0;
            bp_stop_q     <= 1'b0;
            done_q        <= 1'b0;
            cycle_count_q <= '0;
            step_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            remaining_q   <= remaining_d;
            bp_skip_q     <= bp_skip_d;
            bp_stop_q     <= bp_stop_d;
            done_q        <= done_d;
            cycle_count_q <= cycle_count_d;
            step_q        <= bus.step;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.cpu_en      = cpu_en;
    assign bus.state       = state_q;
    assign bus.cycle_count = cycle_count_q;
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.done        = done_q;
    assign bus.bp_stop     = bp_stop_q;

endmodule

// File: tb/tb_i281_run_controller.sv
// ----------------------------------------------------------------------------
// tb_i281_run_controller
//
// Purpose:
//   Self-checking bench for i281_run_controller. It applies directed and
//   randomized run, step, run-N, halt and breakpoint sequences. Each check
//   compares the DUT against expected values that the bench derives from the
//   controller's rules with plain arithmetic: the number of enabled cycles,
//   the number of done pulses, the final state and the saturating count.
//   The bench also acts as a simple CPU. Its program counter advances once
//   for every cycle in which cpu_en is high.
//
// Configuration:
//   If I281_RUN_BREAKPOINT_EN is defined, the breakpoint stop is expected.
//   Otherwise the bench expects that execution continues past the breakpoint
//   address.
// ----------------------------------------------------------------------------
module tb_i281_run_controller;

    localparam int PW   = 6;
    localparam int CW   = 8;    // a narrow counter, so saturation happens early
    localparam int SW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    i281_run_controller_if #(.PC_WIDTH(PW), .CYCLE_WIDTH(CW), .STEP_WIDTH(SW)) bus ();

    i281_run_controller #(.PC_WIDTH(PW), .CYCLE_WIDTH(CW), .STEP_WIDTH(SW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    int   en_cnt, done_cnt, cur_run, en_max;
    logic last_en;
    int   cpu_pc;
    int   exp_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Each call is one clock cycle. The bench samples the outputs at the
    // falling edge and changes its inputs 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clock);
        last_en = bus.cpu_en;
        if (bus.cpu_en === 1'b1) begin
            en_cnt++;
            cur_run++;
            if (cur_run > en_max) en_max = cur_run;
        end else begin
            cur_run = 0;
        end
        if (bus.done === 1'b1) done_cnt++;
        @(posedge clock);
        #1;
        if (last_en === 1'b1) cpu_pc++;
        bus.pc = PW'(cpu_pc);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_mon();
        en_cnt = 0; done_cnt = 0; cur_run = 0; en_max = 0;
    endtask

    task automatic add_exp(input int n);
        exp_count += n;
        if (exp_count > CMAX) exp_count = CMAX;
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.run = 1'b0; bus.step = 1'b0; bus.halt_req = 1'b0;
        tick();
        reset = 1'b0;
        exp_count = 0;
        cpu_pc = 0;
        bus.pc = '0;
    endtask

    task automatic check_phase(input string tag, input int en, input int dn, input int st);
        check({tag, ".en_cycles"}, en_cnt, en);
        check({tag, ".done"}, done_cnt, dn);
        check({tag, ".state"}, bus.state, st);
        check({tag, ".count"}, bus.cycle_count, exp_count);
    endtask

    // Free-run: run is high for l sampled edges. The first edge enters RUN,
    // and the exit cycle with run low still executes. That gives l enabled
    // cycles in one contiguous block.
    task automatic free_run(input int l);
        clear_mon();
        bus.mode = 2'b00; bus.run = 1'b1;
        ticks(l);
        bus.run = 1'b0;
        ticks(4);
        add_exp(l);
        check_phase("free_run", l, 1, 0);
        check("free_run.contig", en_max, l);
    endtask

    // Run-N: a single run pulse gives n consecutive enabled cycles. The mode
    // input is moved away after entry, and that move must not shorten the run.
    task automatic run_n(input int n);
        clear_mon();
        bus.mode = 2'b10; bus.step_count = SW'(n); bus.run = 1'b1;
        tick();
        bus.run = 1'b0; bus.mode = 2'b00;
        ticks(n + 4);
        add_exp(n);
        check_phase("run_n", n, 1, 0);
        check("run_n.contig", en_max, n);
    endtask

    task automatic step_pulses(input int k);
        clear_mon();
        bus.mode = 2'b01;
        for (int i = 0; i < k; i++) begin
            bus.step = 1'b1; ticks($urandom_range(1, 4));
            bus.step = 1'b0; ticks($urandom_range(1, 4));
        end
        ticks(3);
        add_exp(k);
        check_phase("step", k, k, 0);
        check("step.contig", en_max, (k > 0) ? 1 : 0);
    endtask

    task automatic mode_reserved();
        clear_mon();
        bus.mode = 2'b11; bus.run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.step = 1'($urandom);
            tick();
        end
        bus.run = 1'b0; bus.step = 1'b0;
        ticks(2);
        check_phase("mode11", 0, 0, 0);
    endtask

    task automatic halt_toggle();
        for (int i = 0; i < 20; i++) begin
            bus.run = 1'($urandom); bus.step = 1'($urandom); bus.mode = 2'($urandom);
            tick();
        end
        bus.run = 1'b0; bus.step = 1'b0;
    endtask

    initial begin
        int n, k, a;
        reset = 1'b1;
        bus.run = 1'b0; bus.mode = 2'b00; bus.step = 1'b0; bus.step_count = '0;
        bus.halt_req = 1'b0; bus.pc = '0; bus.bp_addr = '0; bus.bp_enable = 1'b0;
        cpu_pc = 0; exp_count = 0; last_en = 1'b0;
        clear_mon();
        ticks(2);

        // The reset state is checked while reset is still asserted.
        check("rst.state", bus.state, 0);
        check("rst.cpu_en", bus.cpu_en, 0);
        check("rst.count", bus.cycle_count, 0);
        check("rst.halted", bus.halted, 0);
        check("rst.done", bus.done, 0);
        check("rst.bp_stop", bus.bp_stop, 0);
        reset = 1'b0;
        tick();

        // Reset mid-RUN: ten run edges give nine executed cycles so far.
        bus.mode = 2'b00; bus.run = 1'b1;
        ticks(10);
        check("midrun.state", bus.state, 1);
        check("midrun.count", bus.cycle_count, 9);
        do_reset();
        check("midrun_rst.state", bus.state, 0);
        check("midrun_rst.cpu_en", bus.cpu_en, 0);
        check("midrun_rst.count", bus.cycle_count, 0);

        // Free-run, then a pause, then a resume from 25.
        free_run(25);
        free_run($urandom_range(1, 30));

        // Single-step: three isolated pulses, then step held high.
        step_pulses(3);
        clear_mon();
        bus.step = 1'b1; ticks(12); bus.step = 1'b0; ticks(3);
        add_exp(1);
        check_phase("step_hold", 1, 1, 0);

        // Run-N with N=5, N=0 and the largest N.
        run_n(5);
        run_n(0);
        run_n((1 << SW) - 1);

        // The reserved mode holds in IDLE.
        mode_reserved();

        // The counter saturates and does not wrap.
        free_run(CMAX + 40);
        check("sat.count", bus.cycle_count, CMAX);
        free_run(5);

        // A randomized mix of transactions.
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0: free_run($urandom_range(1, 30));
                1: run_n($urandom_range(0, 30));
                2: step_pulses($urandom_range(1, 4));
                default: mode_reserved();
            endcase
        end

        // Halt during free-run after k enabled cycles. HALT ignores run and
        // step until reset.
        do_reset();
        k = $urandom_range(3, 12);
        clear_mon();
        bus.mode = 2'b00; bus.run = 1'b1;
        ticks(k);
        bus.halt_req = 1'b1; tick(); bus.halt_req = 1'b0;
        halt_toggle();
        add_exp(k);
        check_phase("halt", k, 0, 3);
        check("halt.halted", bus.halted, 1);
        check("halt.cpu_en", bus.cpu_en, 0);
        do_reset();
        check("halt_rst.state", bus.state, 0);
        check("halt_rst.halted", bus.halted, 0);
        check("halt_rst.count", bus.cycle_count, 0);

        // halt_req coincides with the last run-N cycle, and HALT wins.
        n = $urandom_range(1, 10);
        clear_mon();
        bus.mode = 2'b10; bus.step_count = SW'(n); bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        ticks(n - 1);
        bus.halt_req = 1'b1; tick(); bus.halt_req = 1'b0;
        ticks(3);
        add_exp(n);
        check_phase("halt_runn", n, 0, 3);

        // halt_req during STEP goes to HALT with no done.
        do_reset();
        clear_mon();
        bus.mode = 2'b01; bus.step = 1'b1; tick();
        bus.halt_req = 1'b1; tick();
        bus.halt_req = 1'b0; bus.step = 1'b0; ticks(3);
        add_exp(1);
        check_phase("halt_step", 1, 0, 3);

        // Breakpoint: the CPU pc counts from 0 with cpu_en.
        do_reset();
        a = $urandom_range(2, 20);
        bus.bp_addr = PW'(a); bus.bp_enable = 1'b1;
        clear_mon();
        bus.mode = 2'b00; bus.run = 1'b1;
        ticks(a + 1);
        bus.run = 1'b0;
        ticks(4);
`ifdef I281_RUN_BREAKPOINT_EN
        add_exp(a);
        check_phase("bp", a, 1, 0);
        check("bp.pc", cpu_pc, a);
        check("bp.bp_stop", bus.bp_stop, 1);
`else
        add_exp(a + 1);
        check_phase("bp", a + 1, 1, 0);
        check("bp.pc", cpu_pc, a + 1);
        check("bp.bp_stop", bus.bp_stop, 0);
`endif
        // Resume with a single run pulse: exactly one instruction executes.
        clear_mon();
        bus.run = 1'b1; tick(); bus.run = 1'b0; ticks(4);
        add_exp(1);
        check_phase("bp_resume", 1, 1, 0);
`ifdef I281_RUN_BREAKPOINT_EN
        check("bp_resume.pc", cpu_pc, a + 1);
`else
        check("bp_resume.pc", cpu_pc, a + 2);
`endif
        check("bp_resume.bp_stop", bus.bp_stop, 0);
        bus.bp_enable = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
